// File: rtl/collide_scan_pkg.sv
// Shared game defines (record layout, object types, scan state codes) and the
// collide_scan package built on them.
`ifndef GAME_DEFINES_SVH
`define GAME_DEFINES_SVH
`define GAME_DATACOUNT   4
`define GAME_DATALEN     36
`define COORDLEN    8
`define PLAYERTYPE  4'd1
`define ENEMYTYPE   4'd2
`define TYPE_OFF    0
`define TYPE_LEN    4
`define X_OFF       4
`define Y_OFF       12
`define W_OFF       20
`define H_OFF       28
`define ST_IDLE     2'd0
`define ST_CHECK    2'd1
`define ST_SCAN     2'd2
`define ST_DONE     2'd3
`endif

package collide_scan_pkg;

   typedef enum logic [1:0] {
      IDLE  = `ST_IDLE,
      CHECK = `ST_CHECK,
      SCAN  = `ST_SCAN,
      DONE  = `ST_DONE
   } state_t;

   // One-axis overlap; sums carry an extra bit so large pos+size cannot wrap.
   function automatic logic axis_overlap(
      input logic [`COORDLEN-1:0] p_pos,
      input logic [`COORDLEN-1:0] p_size,
      input logic [`COORDLEN-1:0] e_pos,
      input logic [`COORDLEN-1:0] e_size
   );
      logic [`COORDLEN:0] p_end;
      logic [`COORDLEN:0] e_end;
      p_end = {1'b0, p_pos} + {1'b0, p_size};
      e_end = {1'b0, e_pos} + {1'b0, e_size};
      return !((p_end < {1'b0, e_pos}) || (e_end < {1'b0, p_pos}));
   endfunction

endpackage

// File: rtl/collide_scan_aabb_overlap.sv
// Shared combinational AABB comparator: does the enemy record overlap the player record.
module aabb_overlap
   import collide_scan_pkg::*;
#(
   parameter int DATALEN = `GAME_DATALEN
) (
   input  logic [DATALEN-1:0] player,
   input  logic [DATALEN-1:0] enemy,
   output logic               overlap
);

   logic x_hit;
   logic y_hit;
   // Type fields are judged by the scheduler, not the comparator.
   logic unused_type;

   assign unused_type = ^{player[`TYPE_OFF +: `TYPE_LEN], enemy[`TYPE_OFF +: `TYPE_LEN]};

   assign x_hit = axis_overlap(player[`X_OFF +: `COORDLEN], player[`W_OFF +: `COORDLEN],
                               enemy[`X_OFF +: `COORDLEN],  enemy[`W_OFF +: `COORDLEN]);
   assign y_hit = axis_overlap(player[`Y_OFF +: `COORDLEN], player[`H_OFF +: `COORDLEN],
                               enemy[`Y_OFF +: `COORDLEN],  enemy[`H_OFF +: `COORDLEN]);

   assign overlap = x_hit & y_hit;

endmodule

// File: rtl/collide_scan.sv
// Frame-tick collision scheduler: snapshots the object list and walks enemy
// slots one per clock through a single aabb_overlap instance.
module collide_scan
   import collide_scan_pkg::*;
#(
   parameter int DATACOUNT  = `GAME_DATACOUNT,
   parameter int DATALEN    = `GAME_DATALEN,
   parameter int EARLY_EXIT = 1,
   localparam int IW = (DATACOUNT > 1) ? $clog2(DATACOUNT) : 1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start,
   input  logic [DATALEN*DATACOUNT-1:0]   gamedata,
   output logic                           busy,
   output logic                           done,
   output logic                           collide,
   output logic [IW-1:0]                  hit_index
);

   state_t                         state_reg;
   logic [IW-1:0]                  idx_reg;
   logic [DATALEN*DATACOUNT-1:0]   snap_reg;
   logic                           hit_reg;
   logic [IW-1:0]                  first_reg;

   logic [DATALEN-1:0] slot [DATACOUNT];
   logic [DATALEN-1:0] cur_rec;
   logic               overlap;
   logic               hit_now;
   logic               last_slot;
   logic               is_player;

   genvar gi;
   generate
      for (gi = 0; gi < DATACOUNT; gi++) begin : g_slot
         assign slot[gi] = snap_reg[gi*DATALEN +: DATALEN];
      end
   endgenerate

   assign cur_rec   = slot[idx_reg];
   assign is_player = (slot[0][`TYPE_OFF +: `TYPE_LEN] == `PLAYERTYPE);
   assign hit_now   = (cur_rec[`TYPE_OFF +: `TYPE_LEN] == `ENEMYTYPE) && overlap;
   assign last_slot = (idx_reg == IW'(DATACOUNT-1));

   aabb_overlap #(.DATALEN(DATALEN)) u_aabb (
      .player  (slot[0]),
      .enemy   (cur_rec),
      .overlap (overlap)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg <= IDLE;
         idx_reg   <= '0;
         snap_reg  <= '0;
         hit_reg   <= 1'b0;
         first_reg <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         collide   <= 1'b0;
         hit_index <= '0;
      end else begin
         done <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  snap_reg  <= gamedata;
                  idx_reg   <= IW'(1);
                  hit_reg   <= 1'b0;
                  first_reg <= '0;
                  busy      <= 1'b1;
                  state_reg <= CHECK;
               end
            end
            CHECK: begin
               if (!is_player) begin
                  collide   <= 1'b0;
                  hit_index <= '0;
                  done      <= 1'b1;
                  state_reg <= DONE;
               end else begin
                  state_reg <= SCAN;
               end
            end
            SCAN: begin
               if (hit_now && (EARLY_EXIT != 0)) begin
                  collide   <= 1'b1;
                  hit_index <= idx_reg;
                  done      <= 1'b1;
                  state_reg <= DONE;
               end else begin
                  // Only the first hit index is kept when scanning everything.
                  if (hit_now && !hit_reg) begin
                     hit_reg   <= 1'b1;
                     first_reg <= idx_reg;
                  end
                  if (last_slot) begin
                     collide   <= hit_reg | hit_now;
                     hit_index <= hit_reg ? first_reg : (hit_now ? idx_reg : '0);
                     done      <= 1'b1;
                     state_reg <= DONE;
                  end else begin
                     idx_reg <= idx_reg + IW'(1);
                  end
               end
            end
            DONE: begin
               busy      <= 1'b0;
               state_reg <= IDLE;
            end
            default: begin
               busy      <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_collide_scan.sv
// Directed bench for collide_scan: one early-exit and one full-scan instance.
module tb_collide_scan;

   localparam logic [3:0] T_EMPTY  = 4'd0;
   localparam logic [3:0] T_PLAYER = 4'd1;
   localparam logic [3:0] T_ENEMY  = 4'd2;
   localparam logic [3:0] T_OTHER  = 4'd3;

   logic           clk;
   logic           reset;
   logic           start_a;
   logic           start_b;
   logic [143:0]   gamedata;
   logic           busy_a, done_a, collide_a;
   logic [1:0]     hit_a;
   logic           busy_b, done_b, collide_b;
   logic [1:0]     hit_b;

   int errors = 0;
   int checks = 0;

   collide_scan #(.DATACOUNT(4), .DATALEN(36), .EARLY_EXIT(1)) dut (
      .clk(clk), .reset(reset), .start(start_a), .gamedata(gamedata),
      .busy(busy_a), .done(done_a), .collide(collide_a), .hit_index(hit_a)
   );

   collide_scan #(.DATACOUNT(4), .DATALEN(36), .EARLY_EXIT(0)) dut_full (
      .clk(clk), .reset(reset), .start(start_b), .gamedata(gamedata),
      .busy(busy_b), .done(done_b), .collide(collide_b), .hit_index(hit_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [35:0] rec(input logic [3:0] t, input logic [7:0] x,
                                       input logic [7:0] y, input logic [7:0] w,
                                       input logic [7:0] h);
      return {h, w, y, x, t};
   endfunction

   function automatic logic [35:0] player_rec();
      return rec(T_PLAYER, 8'd10, 8'd0, 8'd5, 8'd8);
   endfunction

   // Pulses start for one edge, then returns the cycle (after the start edge) of done; 0 on timeout.
   task automatic run_scan(input bit on_b, output int lat);
      @(posedge clk); #1;
      if (on_b) start_b = 1'b1; else start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      start_b = 1'b0;
      lat = 0;
      for (int c = 1; c <= 20; c++) begin
         if ((on_b ? done_b : done_a) === 1'b1) begin
            lat = c;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({busy_a, done_a, collide_a, hit_a, busy_b, done_b, collide_b, hit_b} !== 10'b0) begin
         errors++;
         $display("FAIL reset_outputs: got %b want 0000000000",
                  {busy_a, done_a, collide_a, hit_a, busy_b, done_b, collide_b, hit_b});
      end
      reset = 1'b1;
      $display("test_reset: busy=%0d done=%0d collide=%0d hit=%0d", busy_a, done_a, collide_a, hit_a);
   endtask

   task automatic test_touching();
      int lat;
      gamedata = {rec(T_EMPTY, 8'd0, 8'd0, 8'd0, 8'd0),
                  rec(T_ENEMY, 8'd15, 8'd0, 8'd3, 8'd4),
                  rec(T_EMPTY, 8'd0, 8'd0, 8'd0, 8'd0),
                  player_rec()};
      run_scan(1'b0, lat);
      checks++;
      if (lat !== 4) begin errors++; $display("FAIL touch_latency: got %0d want 4", lat); end
      checks++;
      if ({collide_a, hit_a} !== 3'b1_10) begin
         errors++; $display("FAIL touch_result: got collide=%0d hit=%0d want collide=1 hit=2", collide_a, hit_a);
      end
      checks++;
      if (busy_a !== 1'b1) begin errors++; $display("FAIL touch_busy_in_done: got %0d want 1", busy_a); end
      $display("test_touching: lat=%0d collide=%0d hit=%0d", lat, collide_a, hit_a);
      @(posedge clk); #1;
      checks++;
      if ({busy_a, done_a, collide_a, hit_a} !== 5'b0_0_1_10) begin
         errors++; $display("FAIL touch_after_done: got busy=%0d done=%0d collide=%0d hit=%0d want 0 0 1 2",
                            busy_a, done_a, collide_a, hit_a);
      end
   endtask

   task automatic test_miss();
      int lat;
      gamedata = {rec(T_EMPTY, 8'd0, 8'd0, 8'd0, 8'd0),
                  rec(T_OTHER, 8'd10, 8'd0, 8'd5, 8'd8),
                  rec(T_ENEMY, 8'd16, 8'd0, 8'd3, 8'd4),
                  player_rec()};
      run_scan(1'b0, lat);
      checks++;
      if (lat !== 5) begin errors++; $display("FAIL miss_latency: got %0d want 5", lat); end
      checks++;
      if ({collide_a, hit_a} !== 3'b0_00) begin
         errors++; $display("FAIL miss_result: got collide=%0d hit=%0d want collide=0 hit=0", collide_a, hit_a);
      end
      $display("test_miss: lat=%0d collide=%0d hit=%0d", lat, collide_a, hit_a);
   endtask

   task automatic test_axes();
      int lat;
      gamedata = {rec(T_ENEMY, 8'd5, 8'd8, 8'd5, 8'd2),
                  rec(T_ENEMY, 8'd16, 8'd0, 8'd2, 8'd2),
                  rec(T_ENEMY, 8'd10, 8'd9, 8'd2, 8'd2),
                  player_rec()};
      run_scan(1'b0, lat);
      checks++;
      if (lat !== 5) begin errors++; $display("FAIL axes_latency: got %0d want 5", lat); end
      checks++;
      if ({collide_a, hit_a} !== 3'b1_11) begin
         errors++; $display("FAIL axes_result: got collide=%0d hit=%0d want collide=1 hit=3", collide_a, hit_a);
      end
      $display("test_axes: lat=%0d collide=%0d hit=%0d", lat, collide_a, hit_a);
   endtask

   task automatic test_no_player();
      int lat;
      gamedata = {rec(T_ENEMY, 8'd10, 8'd0, 8'd5, 8'd8),
                  rec(T_ENEMY, 8'd10, 8'd0, 8'd5, 8'd8),
                  rec(T_ENEMY, 8'd10, 8'd0, 8'd5, 8'd8),
                  rec(T_ENEMY, 8'd10, 8'd0, 8'd5, 8'd8)};
      run_scan(1'b0, lat);
      checks++;
      if (lat !== 2) begin errors++; $display("FAIL noplayer_latency: got %0d want 2", lat); end
      checks++;
      if ({collide_a, hit_a} !== 3'b0_00) begin
         errors++; $display("FAIL noplayer_result: got collide=%0d hit=%0d want collide=0 hit=0", collide_a, hit_a);
      end
      $display("test_no_player: lat=%0d collide=%0d hit=%0d", lat, collide_a, hit_a);
   endtask

   task automatic test_two_hits();
      int lat;
      gamedata = {rec(T_ENEMY, 8'd12, 8'd2, 8'd2, 8'd2),
                  rec(T_EMPTY, 8'd0, 8'd0, 8'd0, 8'd0),
                  rec(T_ENEMY, 8'd10, 8'd0, 8'd2, 8'd2),
                  player_rec()};
      run_scan(1'b1, lat);
      checks++;
      if (lat !== 5) begin errors++; $display("FAIL full_latency: got %0d want 5", lat); end
      checks++;
      if ({collide_b, hit_b} !== 3'b1_01) begin
         errors++; $display("FAIL full_first_hit: got collide=%0d hit=%0d want collide=1 hit=1", collide_b, hit_b);
      end
      $display("test_two_hits full: lat=%0d collide=%0d hit=%0d", lat, collide_b, hit_b);
      run_scan(1'b0, lat);
      checks++;
      if (lat !== 3 || {collide_a, hit_a} !== 3'b1_01) begin
         errors++; $display("FAIL early_first_hit: got lat=%0d collide=%0d hit=%0d want lat=3 collide=1 hit=1",
                            lat, collide_a, hit_a);
      end
      $display("test_two_hits early: lat=%0d collide=%0d hit=%0d", lat, collide_a, hit_a);
   endtask

   task automatic test_back_to_back_busy();
      int lat;
      int extra;
      gamedata = {rec(T_EMPTY, 8'd0, 8'd0, 8'd0, 8'd0),
                  rec(T_ENEMY, 8'd15, 8'd0, 8'd3, 8'd4),
                  rec(T_EMPTY, 8'd0, 8'd0, 8'd0, 8'd0),
                  player_rec()};
      @(posedge clk); #1;
      start_a = 1'b1;
      @(posedge clk); #1;
      lat = 0;
      for (int c = 1; c <= 20; c++) begin
         if (c == 2) begin
            gamedata = {rec(T_EMPTY, 8'd0, 8'd0, 8'd0, 8'd0),
                        rec(T_EMPTY, 8'd0, 8'd0, 8'd0, 8'd0),
                        rec(T_ENEMY, 8'd10, 8'd0, 8'd5, 8'd8),
                        player_rec()};
         end
         start_a = (c <= 3);
         if (done_a === 1'b1) begin
            lat = c;
            break;
         end
         @(posedge clk); #1;
      end
      start_a = 1'b0;
      checks++;
      if (lat !== 4 || {collide_a, hit_a} !== 3'b1_10) begin
         errors++; $display("FAIL busy_snapshot: got lat=%0d collide=%0d hit=%0d want lat=4 collide=1 hit=2",
                            lat, collide_a, hit_a);
      end
      extra = 0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         if (done_a === 1'b1) extra++;
      end
      checks++;
      if (extra !== 0) begin errors++; $display("FAIL busy_start_queued: got %0d extra done want 0", extra); end
      $display("test_back_to_back_busy: lat=%0d collide=%0d hit=%0d extra_done=%0d", lat, collide_a, hit_a, extra);
   endtask

   task automatic test_reset_mid_scan();
      int lat;
      int stray;
      gamedata = {rec(T_EMPTY, 8'd0, 8'd0, 8'd0, 8'd0),
                  rec(T_EMPTY, 8'd0, 8'd0, 8'd0, 8'd0),
                  rec(T_ENEMY, 8'd16, 8'd0, 8'd3, 8'd4),
                  player_rec()};
      @(posedge clk); #1;
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      checks++;
      if ({busy_a, done_a, collide_a, hit_a} !== 5'b0) begin
         errors++; $display("FAIL midscan_reset: got busy=%0d done=%0d collide=%0d hit=%0d want 0 0 0 0",
                            busy_a, done_a, collide_a, hit_a);
      end
      reset = 1'b1;
      stray = 0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         if (done_a === 1'b1 || busy_a === 1'b1) stray++;
      end
      checks++;
      if (stray !== 0) begin errors++; $display("FAIL midscan_no_done: got %0d active cycles want 0", stray); end
      $display("test_reset_mid_scan: busy=%0d done=%0d collide=%0d", busy_a, done_a, collide_a);
      gamedata = {rec(T_EMPTY, 8'd0, 8'd0, 8'd0, 8'd0),
                  rec(T_ENEMY, 8'd15, 8'd0, 8'd3, 8'd4),
                  rec(T_EMPTY, 8'd0, 8'd0, 8'd0, 8'd0),
                  player_rec()};
      run_scan(1'b0, lat);
      checks++;
      if (lat !== 4 || {collide_a, hit_a} !== 3'b1_10) begin
         errors++; $display("FAIL after_reset_scan: got lat=%0d collide=%0d hit=%0d want lat=4 collide=1 hit=2",
                            lat, collide_a, hit_a);
      end
      $display("test_reset_mid_scan restart: lat=%0d collide=%0d hit=%0d", lat, collide_a, hit_a);
   endtask

   initial begin
      reset    = 1'b0;
      start_a  = 1'b0;
      start_b  = 1'b0;
      gamedata = '0;
      test_reset();
      test_touching();
      test_miss();
      test_axes();
      test_no_player();
      test_two_hits();
      test_back_to_back_busy();
      test_reset_mid_scan();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/collide_scan.md
# collide_scan

Sequential collision scheduler for the dino game datapath. On each frame tick it snapshots the packed object list and scans enemy slots one per clock through a single shared AABB comparator, instead of instantiating one comparator per slot. It reports a registered collide flag, the index of the first hit, and a one-cycle done pulse to the game-state logic.

## Interface
- `DATACOUNT`, default `` `datacount ``: number of object slots; slot 0 is the player.
- `DATALEN`, default `` `datalen ``: bits per object record.
- `EARLY_EXIT`, default 1: 1 = end the scan on the first hit; 0 = always scan all slots.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-low.
- `start`  in  1  frame tick. Sampled only when `busy`=0.
- `gamedata`  in  DATALEN*DATACOUNT  packed records. Slot i is at `[i*DATALEN +: DATALEN]`. Fields are type, x, y, width, height, at the shared offsets.
- `busy`  out  1  scan in progress.
- `done`  out  1  one-cycle pulse when the result is valid.
- `collide`  out  1  registered result of the last completed scan.
- `hit_index`  out  $clog2(DATACOUNT)  slot of the first colliding enemy; 0 if none.

## Operation
- **States:** IDLE, CHECK, SCAN, DONE. One-hot or binary encoding.
- **IDLE:** `busy`=0. When `start`=1:
  - register the whole `gamedata` into a snapshot;
  - set idx=1 and clear the internal hit flag;
  - go to CHECK.
- **CHECK:** if snapshot slot 0 type ≠ `` `playertype ``, set the result to collide=0, hit_index=0 and go to DONE. Otherwise go to SCAN.
- **SCAN:** evaluate slot idx against slot 0.
  - A hit requires type == `` `enemytype `` and an overlap in both X and Y.
  - On a hit with EARLY_EXIT=1: latch collide=1, hit_index=idx, go to DONE.
  - On a hit with EARLY_EXIT=0: record the first hit index only, and keep scanning.
  - If idx == DATACOUNT-1, go to DONE; otherwise idx++.
- **DONE:**
  - `done`=1 for exactly this cycle;
  - `collide`/`hit_index` take the latched result on entry to this state;
  - return to IDLE.
- **Overlap rule, per axis:** no overlap iff p.pos+p.size < e.pos, or e.pos+e.size < p.pos.
  - Sums are computed one bit wider than the field, so there is no wraparound.
  - The comparison is strict: touching edges count as a collision.
- Non-enemy slots (any type other than `` `enemytype ``) never hit.
- `start` during busy (CHECK/SCAN/DONE) is ignored; it is not queued.
- `gamedata` changes during a scan have no effect; only the snapshot is used.
- `collide`/`hit_index` hold their value between scans. They change only on entry to DONE.

## Timing
- **Reset (reset=0 at a clock edge):** state=IDLE, idx=0, busy=0, done=0, collide=0, hit_index=0, snapshot cleared.
  - Reset mid-scan aborts the scan with no done pulse.
  - Reset has priority over `start`.
- `start` sampled at edge 0 → `busy`=1 from cycle 1.
- **Latency to `done`, counted in cycles after the start edge:**
  - full scan: DATACOUNT+1;
  - early hit at slot k: k+2;
  - non-player slot 0: 2.
- `busy` deasserts in the cycle after DONE. The earliest accepted restart is `start` high in that cycle.
- `done` and `busy` are both high in the DONE cycle.

## Structure
- Field offsets and lengths, `` `datacount ``, `` `datalen ``, `` `playertype `` and `` `enemytype `` come from the shared game defines header. No local copies.
- State encoding constants go in the same shared header.
- One sub-module, `aabb_overlap`: purely combinational.
  - Inputs: two records.
  - Output: overlap, using the X and Y rule above.
- The top level holds the FSM, the snapshot register, the idx counter and the result registers.

## Test plan
DATACOUNT=4 for all scenarios. Player record: type=player, x=10, w=5, y=0, h=8.
- **Touching edge:** enemy in slot 2 with x=15, w=3, y=0, h=4; slots 1 and 3 are empty type. `start` → `done` 4 cycles later (k+2 with k=2, EARLY_EXIT=1), collide=1, hit_index=2.
- **Miss:** single enemy with x=16. `start` → `done` at cycle 5 (DATACOUNT+1), collide=0, hit_index=0.
- **No player:** slot 0 type=enemy. `start` → `done` at cycle 2, collide=0, hit_index=0.
- **EARLY_EXIT=0, two hits:** hits in slots 1 and 3 → `done` at cycle 5, hit_index=1.
- **Start and gamedata changes while busy:** `start` pulsed while busy, and `gamedata` modified mid-scan → no second `done`; the result matches the snapshot.
- **Reset mid-scan:** reset=0 during SCAN → the next cycle shows busy=0, done=0, collide=0; a later `start` scans normally.
